// File: rtl/pow_arb_if.sv
// Bundles the requester, response and pow-unit signals of the modular-exponentiation arbiter.
// master: arbiter side (drives req_ready, rsp_*, pow_start, pow_a/b/p).
// slave:  environment side (requesters, response sink and the shared pow unit).
interface pow_arb_if #(
    parameter int W    = 128,
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    // requester side: per-requester valid, one-hot accept, packed operand slices
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*W-1:0] req_p;

    // response side
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_res;
    logic              rsp_err;

    // shared pow unit
    logic              pow_start;
    logic [W-1:0]      pow_a;
    logic [W-1:0]      pow_b;
    logic [W-1:0]      pow_p;
    logic [W-1:0]      pow_res;
    logic              pow_valid;

    modport master (
        input  req_valid, req_a, req_b, req_p, rsp_ready, pow_res, pow_valid,
        output req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, pow_start, pow_a, pow_b, pow_p
    );

    modport slave (
        output req_valid, req_a, req_b, req_p, rsp_ready, pow_res, pow_valid,
        input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, pow_start, pow_a, pow_b, pow_p
    );
endinterface

// File: rtl/pow_arb.sv
// Round-robin arbiter sharing one pow unit (a^b mod p) among NREQ requesters, one job in flight.
// Latency: grant T, pow_start T+1, rsp_valid the cycle after pow_valid is sampled high in BUSY.
// Backpressure: rsp_valid holds id/res/err until rsp_ready; no new grant until the handshake.
//
// Ports: clk, rst (async, active-high); bus (pow_arb_if.master) carrying
//   req_valid/req_ready/req_a/req_b/req_p, rsp_valid/rsp_ready/rsp_id/rsp_res/rsp_err,
//   pow_start/pow_a/pow_b/pow_p/pow_res/pow_valid.
// Optional: define POW_ARB_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT cycles that
//   completes the job with rsp_err=1, rsp_res=0. Undefined: rsp_err is 0 and BUSY waits forever.
module pow_arb #(
    parameter int W       = 128,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic      clk,
    input  logic      rst,
    pow_arb_if.master bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("pow_arb: NREQ must be 2..8 and TIMEOUT 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] gnt_id;
    logic [IDW:0]   rr_idx;
    logic           gnt_found;
    logic           grant;
    logic           tmo;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   p_q;
    logic [W-1:0]   res_q;

    // Round-robin search starting at ptr; one extra bit in rr_idx keeps ptr+k from overflowing
    // before the wrap back into 0..NREQ-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        rr_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = {1'b0, ptr} + (IDW+1)'(k);
            if (rr_idx >= (IDW+1)'(NREQ)) begin
                rr_idx = rr_idx - (IDW+1)'(NREQ);
            end
            if (!gnt_found && bus.req_valid[rr_idx[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = rr_idx[IDW-1:0];
            end
        end
    end

    // Gated by rst so req_ready stays low during reset even with requests pending.
    assign grant = (state == IDLE) && gnt_found && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.pow_start = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    bus.req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
                    state_nxt     = LAUNCH;
                end
            end
            LAUNCH: begin
                bus.pow_start = 1'b1;
                state_nxt     = BUSY;
            end
            BUSY: begin
                if (bus.pow_valid || tmo) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured at the grant and stay on pow_a/b/p until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            id_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            res_q <= '0;
        end else begin
            if (grant) begin
                id_q <= gnt_id;
                a_q  <= bus.req_a[int'(gnt_id)*W +: W];
                b_q  <= bus.req_b[int'(gnt_id)*W +: W];
                p_q  <= bus.req_p[int'(gnt_id)*W +: W];
            end
            if (state == BUSY) begin
                if (bus.pow_valid) begin
                    res_q <= bus.pow_res;
                end else if (tmo) begin
                    res_q <= '0;
                end
            end
            // Next search starts just past the requester that was served.
            if (state == RESP && bus.rsp_ready) begin
                ptr <= (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
            end
        end
    end

`ifdef POW_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        err_q;

    // Fires in the BUSY cycle whose increment would bring the count to TIMEOUT, so RESP
    // follows the TIMEOUT-th idle BUSY cycle.
    assign tmo = ({1'b0, wd_cnt} + 17'd1) == 17'(TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            // LAUNCH is the only way into BUSY, so clearing there is clearing on entry.
            if (state == LAUNCH) begin
                wd_cnt <= '0;
            end else if (state == BUSY && !bus.pow_valid) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (state == BUSY) begin
                if (bus.pow_valid) begin
                    err_q <= 1'b0;
                end else if (tmo) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign tmo         = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.rsp_id  = id_q;
    assign bus.rsp_res = res_q;
    assign bus.pow_a   = a_q;
    assign bus.pow_b   = b_q;
    assign bus.pow_p   = p_q;
endmodule
